// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// FSM states, iteration count and the divide-by-zero quotient.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int ITER = 32;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Iterative shift-add multiply / restoring divide datapath working on operand
// magnitudes; the sign correction is applied combinationally on the result.
// Division hardware exists only when MULDIV_DIV_EN is defined.
module muldiv_dp
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        signed_i,
`ifdef MULDIV_DIV_EN
  input  logic        isDiv_i,
`endif
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] resHi_o,
  output logic [31:0] resLo_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        negRes_q, negRes_d;

  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag;
  logic [32:0] addSum;
  logic [63:0] multNext;
  logic [63:0] prodFix;

  always_comb begin
    aNeg     = signed_i & a_i[31];
    bNeg     = signed_i & b_i[31];
    aMag     = aNeg ? neg32(a_i) : a_i;
    bMag     = bNeg ? neg32(b_i) : b_i;
    // acc holds {partial product, remaining multiplier bits}
    addSum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    multNext = {addSum, acc_q[31:1]};
    prodFix  = negRes_q ? (~acc_q + 64'd1) : acc_q;
  end

`ifdef MULDIV_DIV_EN
  logic        isDiv_q, isDiv_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;
  logic [31:0] aRaw_q, aRaw_d;
  logic [32:0] remShift;
  logic        remGe;
  logic [31:0] remSub;
  logic [63:0] divNext;
  logic [31:0] quoFix, remFix;

  // acc holds {partial remainder, dividend bits shifting in / quotient bits}
  always_comb begin
    remShift = {acc_q[63:32], acc_q[31]};
    remGe    = remShift >= {1'b0, opnd_q};
    remSub   = remShift[31:0] - opnd_q;
    divNext  = remGe ? {remSub, acc_q[30:0], 1'b1}
                     : {remShift[31:0], acc_q[30:0], 1'b0};
    quoFix   = negRes_q ? neg32(acc_q[31:0]) : acc_q[31:0];
    remFix   = negRem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
  end

  always_comb begin
    if (!isDiv_q) begin
      {resHi_o, resLo_o} = prodFix;
    end else if (divZero_q) begin
      {resHi_o, resLo_o} = {aRaw_q, DIV0_LO};
    end else begin
      {resHi_o, resLo_o} = {remFix, quoFix};
    end
  end
`else
  always_comb begin
    {resHi_o, resLo_o} = prodFix;
  end
`endif

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    negRes_d = negRes_q;
`ifdef MULDIV_DIV_EN
    isDiv_d   = isDiv_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    aRaw_d    = aRaw_q;
`endif
    if (load_i) begin
      acc_d    = {32'd0, aMag};
      opnd_d   = bMag;
      negRes_d = aNeg ^ bNeg;
`ifdef MULDIV_DIV_EN
      isDiv_d   = isDiv_i;
      negRem_d  = aNeg;
      divZero_d = (b_i == 32'd0);
      aRaw_d    = a_i;
`endif
    end else if (step_i) begin
`ifdef MULDIV_DIV_EN
      acc_d = isDiv_q ? divNext : multNext;
`else
      acc_d = multNext;
`endif
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    negRes_q <= negRes_d;
`ifdef MULDIV_DIV_EN
    isDiv_q   <= isDiv_d;
    negRem_q  <= negRem_d;
    divZero_q <= divZero_d;
    aRaw_q    <= aRaw_d;
`endif
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MIPS-style HI/LO multiply/divide unit: FSM, iteration counter
// and HI/LO registers. Division is enabled by defining MULDIV_DIV_EN.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        illegal_q, illegal_d;

  logic        isDivOp, signedOp, opLegal;
  logic        accept, launch, calcLast;
  logic [31:0] resHi, resLo;

  always_comb begin
    isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
    signedOp = (op == OP_MULT) || (op == OP_DIV);
`ifdef MULDIV_DIV_EN
    opLegal  = 1'b1;
`else
    opLegal  = !isDivOp;
`endif
    accept   = start && !busy;
    launch   = accept && opLegal;
    calcLast = (cnt_q == 5'(ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = launch ? CALC : IDLE;
      CALC:    state_d = calcLast ? FIX : CALC;
      FIX:     state_d = DONE;
      DONE:    state_d = launch ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // A start accepted in the same cycle takes priority over mthi/mtlo writes
  always_comb begin
    cnt_d     = (state_q == CALC) ? cnt_q + 5'd1 : 5'd0;
    illegal_d = accept && !opLegal;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == FIX) begin
      hi_d = resHi;
      lo_d = resLo;
    end else if (!busy && !accept) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 5'd0;
      illegal_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign illegal = illegal_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  muldiv_dp u_dp (
    .clk      (clk),
    .load_i   (launch),
    .step_i   (state_q == CALC),
    .signed_i (signedOp),
`ifdef MULDIV_DIV_EN
    .isDiv_i  (isDivOp),
`endif
    .a_i      (a),
    .b_i      (b),
    .resHi_o  (resHi),
    .resLo_o  (resLo)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations push expected HI/LO and
// completion cycle; a negedge monitor checks every done/illegal pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, illegal;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCyc;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pendingIllegal = 0;

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge N).
  // done is then visible after edge N+33, i.e. sampled at edge N+34.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eh, input logic [31:0] el, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (push) sbq.push_back('{hi: eh, lo: el, doneCyc: cyc + 33});
  endtask

  task automatic waitIdle();
    int k = 0;
    while ((busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("waitIdle", 64'(k < 100), 64'd1);
  endtask

  task automatic waitDone();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("waitDone", 64'(k < 100), 64'd1);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d want no pending result", cyc);
      end else begin
        cur = sbq.pop_front();
        total++;
        if ({hi, lo} !== {cur.hi, cur.lo}) begin
          bad++;
          $display("[TB] FAIL result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, cur.hi, cur.lo);
        end
        total++;
        if (cyc != cur.doneCyc) begin
          bad++;
          $display("[TB] FAIL doneLatency: got cycle %0d want cycle %0d", cyc, cur.doneCyc);
        end
      end
    end
    if (reset && illegal) begin
      total++;
      if (pendingIllegal == 0) begin
        bad++;
        $display("[TB] FAIL unexpectedIllegal: got illegal=1 want 0");
      end else begin
        pendingIllegal--;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] starting muldiv_seq bench");
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetIllegal", 64'(illegal), 64'd0);
    checkOutput("resetHiLo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Direct HI/LO writes while idle
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthiIdle", {hi, lo}, {32'h1234_5678, 32'h0});
    mtlo = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtloIdle", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    // MULTU max*max with cycle-by-cycle busy trace
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 33; i++) begin
      checkOutput("busyTrace", 64'(busy), 64'd1);
      @(negedge clk);
    end
    checkOutput("doneBusyLow", 64'(busy), 64'd0);
    checkOutput("donePulse", 64'(done), 64'd1);
    waitIdle();

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    waitIdle();
    applyStimulus(OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b1);
    waitIdle();
    applyStimulus(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1);
    waitIdle();
    applyStimulus(OP_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1);
    waitIdle();

    // start and mthi during CALC are both ignored
    applyStimulus(OP_MULT, 32'd3, 32'd4, 32'h0, 32'hC, 1'b1);
    repeat (5) @(negedge clk);
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    mthi = 1'b0;
    checkOutput("mthiDuringCalc", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("busyDuringCalc", 64'(busy), 64'd1);
    waitIdle();

    // mthi in the same cycle as an accepted start is dropped
    mthi = 1'b1; wdata = 32'hABCD_0000;
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h6, 1'b1);
    mthi = 1'b0;
    checkOutput("mthiWithStart", 64'(hi), 64'h0);

    // Back-to-back start accepted while in DONE
    waitDone();
    applyStimulus(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'hFFFE_0001, 1'b1);
    waitIdle();

`ifdef MULDIV_DIV_EN
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    waitIdle();
    applyStimulus(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b1);
    waitIdle();
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    waitIdle();
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b1);
    waitIdle();
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
`else
    pendingIllegal = 1;
    applyStimulus(OP_DIV, 32'd9, 32'd3, 32'h0, 32'h0, 1'b0);
    checkOutput("illegalBusy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("illegalSeen", 64'(pendingIllegal), 64'd0);
    checkOutput("illegalOneCycle", 64'(illegal), 64'd0);
    checkOutput("illegalHiLo", {hi, lo}, {32'h0, 32'hFFFE_0001});
    pendingIllegal = 1;
    applyStimulus(OP_DIVU, 32'd9, 32'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("illegalDivuSeen", 64'(pendingIllegal), 64'd0);
    checkOutput("illegalDivuState", {31'd0, busy, hi, lo}, {32'h0, 32'h0, 32'hFFFE_0001});
`endif

    // Reset in the middle of CALC aborts with no done and cleared HI/LO
    applyStimulus(OP_MULTU, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("busyBeforeAbort", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortHiLo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("abortNoDone", {63'd0, done}, 64'd0);
    checkOutput("abortHiLoHeld", {hi, lo}, 64'd0);

    checkOutput("scoreboardEmpty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
